// File: rtl/pitch_count_if.sv
// Pitch roulette signal bundle: the switch and clear pulses go in, the count LEDs and
// walk/strikeout pulses come out. The bench drives it through master, the block uses slave.
interface pitch_count_if;
   logic       pitch_sw_n;
   logic       pa_end;
   logic       change_pulse;
   logic       walk_pulse;
   logic       strikeout_pulse;
   logic [2:0] ball_led;
   logic [1:0] strike_led;
   logic [7:0] pitch_led;

   modport master (
      output pitch_sw_n, pa_end, change_pulse,
      input  walk_pulse, strikeout_pulse, ball_led, strike_led, pitch_led
   );

   modport slave (
      input  pitch_sw_n, pa_end, change_pulse,
      output walk_pulse, strikeout_pulse, ball_led, strike_led, pitch_led
   );
endinterface

// File: rtl/pitch_count.sv
// Pitch roulette: judges each pitch as ball or strike and keeps the ball/strike count.
// Optional macro PITCH_FOUL_EN: roulette position 3 is a foul and cannot be a third strike.
module pitch_count (
   input  logic          clk,
   input  logic          reset_n,
   pitch_count_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SPIN, JUDGE} state_t;

   state_t     r_state, w_state_nxt;
   logic [1:0] r_sync;
   logic       w_pitch;
   logic [2:0] r_pos, w_pos_nxt;
   logic       r_wait_rel, w_wait_nxt;
   logic [2:0] r_ball_led, w_ball_nxt;
   logic [1:0] r_strike_led, w_strike_nxt;
   logic [7:0] r_pitch_led, w_led_nxt;
   logic       r_walk, w_walk_nxt;
   logic       r_so, w_so_nxt;
   logic       w_clear;
   logic       w_is_ball;
   logic       w_is_foul;

   assign w_pitch   = ~r_sync[1];
   assign w_clear   = bus.pa_end | bus.change_pulse;
   assign w_is_ball = r_pos[2];
`ifdef PITCH_FOUL_EN
   assign w_is_foul = (r_pos == 3'd3);
`else
   assign w_is_foul = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      case (r_state)
         IDLE: begin
            if (w_pitch && !r_wait_rel) begin
               w_state_nxt = SPIN;
               w_pos_nxt   = 3'd0;
            end
         end
         SPIN: begin
            if (w_pitch) w_pos_nxt   = r_pos + 3'd1;
            else         w_state_nxt = JUDGE;
         end
         JUDGE:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (bus.change_pulse) w_state_nxt = IDLE;
   end

   // A side change abandons the pitch; a still-held switch must be released before respinning.
   always_comb begin
      w_wait_nxt = r_wait_rel;
      if (bus.change_pulse) w_wait_nxt = 1'b1;
      else if (!w_pitch)    w_wait_nxt = 1'b0;
   end

   // Counts are kept directly as thermometer codes: the top bit set means "one more ends it".
   always_comb begin
      w_ball_nxt   = r_ball_led;
      w_strike_nxt = r_strike_led;
      w_walk_nxt   = 1'b0;
      w_so_nxt     = 1'b0;
      if (w_clear) begin
         w_ball_nxt   = 3'b000;
         w_strike_nxt = 2'b00;
      end else if (r_state == JUDGE) begin
         if (w_is_ball) begin
            if (r_ball_led[2]) begin
               w_walk_nxt   = 1'b1;
               w_ball_nxt   = 3'b000;
               w_strike_nxt = 2'b00;
            end else begin
               w_ball_nxt = {r_ball_led[1:0], 1'b1};
            end
         end else if (r_strike_led[1]) begin
            if (!w_is_foul) begin
               w_so_nxt     = 1'b1;
               w_ball_nxt   = 3'b000;
               w_strike_nxt = 2'b00;
            end
         end else begin
            w_strike_nxt = {r_strike_led[0], 1'b1};
         end
      end
   end

   always_comb begin
      w_led_nxt = r_pitch_led;
      if (bus.change_pulse)
         w_led_nxt = 8'h00;
      else if (w_state_nxt == SPIN || w_state_nxt == JUDGE)
         w_led_nxt = 8'd1 << w_pos_nxt;
      else if (bus.pa_end)
         w_led_nxt = 8'h00;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync       <= 2'b11;
         r_state      <= IDLE;
         r_pos        <= 3'd0;
         r_wait_rel   <= 1'b0;
         r_ball_led   <= 3'b000;
         r_strike_led <= 2'b00;
         r_pitch_led  <= 8'h00;
         r_walk       <= 1'b0;
         r_so         <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], bus.pitch_sw_n};
         r_state      <= w_state_nxt;
         r_pos        <= w_pos_nxt;
         r_wait_rel   <= w_wait_nxt;
         r_ball_led   <= w_ball_nxt;
         r_strike_led <= w_strike_nxt;
         r_pitch_led  <= w_led_nxt;
         r_walk       <= w_walk_nxt;
         r_so         <= w_so_nxt;
      end
   end

   assign bus.walk_pulse      = r_walk;
   assign bus.strikeout_pulse = r_so;
   assign bus.ball_led        = r_ball_led;
   assign bus.strike_led      = r_strike_led;
   assign bus.pitch_led       = r_pitch_led;

endmodule

// File: tb/tb_pitch_count.sv
// Directed bench for pitch_count: walks, strikeouts, the position-3 pitch, clear priority,
// roulette wrap with side change, and asynchronous reset in SPIN.
module tb_pitch_count;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [2:0] ball_seq [4];
   logic [1:0] strike_seq [3];

   pitch_count_if bus ();

   pitch_count u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Hold the switch n cycles; returns in the JUDGE cycle with pos frozen at (n-1) mod 8.
   task automatic to_judge(input int n);
      bus.pitch_sw_n = 1'b0;
      repeat (n) tick();
      bus.pitch_sw_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic pitch(input int n);
      to_judge(n);
      repeat (2) tick();
   endtask

   initial begin
      ball_seq   = '{3'b001, 3'b011, 3'b111, 3'b000};
      strike_seq = '{2'b01, 2'b11, 2'b00};
      bus.pitch_sw_n   = 1'b1;
      bus.pa_end       = 1'b0;
      bus.change_pulse = 1'b0;
      reset_n          = 1'b0;
      repeat (2) tick();
      chk("rst_ball", bus.ball_led, 3'b000);
      chk("rst_strike", bus.strike_led, 2'b00);
      chk("rst_pled", bus.pitch_led, 8'h00);
      chk("rst_walk", bus.walk_pulse, 1'b0);
      chk("rst_so", bus.strikeout_pulse, 1'b0);
      reset_n = 1'b1;
      tick();

      // four balls at pos 5 -> walk
      for (int i = 0; i < 4; i++) begin
         to_judge(6);
         chk("ball_pled", bus.pitch_led, 8'h20);
         chk("ball_walk_early", bus.walk_pulse, 1'b0);
         tick();
         chk("ball_count", bus.ball_led, ball_seq[i]);
         chk("ball_walk", bus.walk_pulse, (i == 3) ? 1 : 0);
         chk("ball_so", bus.strikeout_pulse, 1'b0);
         if (i == 0) chk("ball_pled_hold", bus.pitch_led, 8'h20);
         tick();
         chk("ball_walk_drop", bus.walk_pulse, 1'b0);
      end

      // three strikes at pos 1 -> strikeout
      for (int i = 0; i < 3; i++) begin
         to_judge(2);
         chk("str_pled", bus.pitch_led, 8'h02);
         tick();
         chk("str_count", bus.strike_led, strike_seq[i]);
         chk("str_so", bus.strikeout_pulse, (i == 2) ? 1 : 0);
         chk("str_walk", bus.walk_pulse, 1'b0);
         tick();
         chk("str_so_drop", bus.strikeout_pulse, 1'b0);
      end

      // two strikes, then a pitch frozen at pos 3
      pitch(2);
      pitch(2);
      chk("p3_pre", bus.strike_led, 2'b11);
      to_judge(4);
      chk("p3_pled", bus.pitch_led, 8'h08);
      tick();
`ifdef PITCH_FOUL_EN
      chk("p3_strike", bus.strike_led, 2'b11);
      chk("p3_so", bus.strikeout_pulse, 1'b0);
`else
      chk("p3_strike", bus.strike_led, 2'b00);
      chk("p3_so", bus.strikeout_pulse, 1'b1);
`endif
      tick();
      chk("p3_so_drop", bus.strikeout_pulse, 1'b0);
      bus.pa_end = 1'b1;
      tick();
      bus.pa_end = 1'b0;
      chk("p3_clear", bus.strike_led, 2'b00);

      // full count, pa_end in the JUDGE cycle of a ball pitch
      repeat (3) pitch(6);
      repeat (2) pitch(2);
      chk("full_ball", bus.ball_led, 3'b111);
      chk("full_strike", bus.strike_led, 2'b11);
      to_judge(7);
      chk("full_pled", bus.pitch_led, 8'h40);
      bus.pa_end = 1'b1;
      tick();
      bus.pa_end = 1'b0;
      chk("clr_ball", bus.ball_led, 3'b000);
      chk("clr_strike", bus.strike_led, 2'b00);
      chk("clr_walk", bus.walk_pulse, 1'b0);
      chk("clr_so", bus.strikeout_pulse, 1'b0);
      chk("clr_pled", bus.pitch_led, 8'h00);
      tick();
      chk("clr_walk_late", bus.walk_pulse, 1'b0);

      // 10-cycle hold wraps to pos 1; then side change during a spin
      to_judge(10);
      chk("wrap_pled", bus.pitch_led, 8'h02);
      tick();
      chk("wrap_strike", bus.strike_led, 2'b01);
      chk("wrap_ball", bus.ball_led, 3'b000);
      tick();
      bus.pitch_sw_n = 1'b0;
      repeat (4) tick();
      chk("chg_spin_pled", bus.pitch_led, 8'h02);
      bus.change_pulse = 1'b1;
      tick();
      bus.change_pulse = 1'b0;
      chk("chg_strike", bus.strike_led, 2'b00);
      chk("chg_pled", bus.pitch_led, 8'h00);
      chk("chg_so", bus.strikeout_pulse, 1'b0);
      chk("chg_walk", bus.walk_pulse, 1'b0);
      repeat (3) tick();
      chk("chg_no_respin", bus.pitch_led, 8'h00);
      bus.pitch_sw_n = 1'b1;
      repeat (4) tick();
      chk("chg_rel_pled", bus.pitch_led, 8'h00);
      chk("chg_rel_strike", bus.strike_led, 2'b00);
      chk("chg_rel_so", bus.strikeout_pulse, 1'b0);

      // asynchronous reset while spinning with two balls
      repeat (2) pitch(6);
      chk("rs_pre_ball", bus.ball_led, 3'b011);
      bus.pitch_sw_n = 1'b0;
      repeat (4) tick();
      chk("rs_spin_pled", bus.pitch_led, 8'h02);
      #1 reset_n = 1'b0;
      #1;
      chk("rs_ball", bus.ball_led, 3'b000);
      chk("rs_strike", bus.strike_led, 2'b00);
      chk("rs_pled", bus.pitch_led, 8'h00);
      chk("rs_walk", bus.walk_pulse, 1'b0);
      chk("rs_so", bus.strikeout_pulse, 1'b0);
      bus.pitch_sw_n = 1'b1;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      to_judge(1);
      chk("rs_first_pled", bus.pitch_led, 8'h01);
      tick();
      chk("rs_first_strike", bus.strike_led, 2'b01);
      chk("rs_first_ball", bus.ball_led, 3'b000);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pitch_count.md
# pitch_count

Defensive-side counterpart of the batting roulette: a pitch roulette driven by a pitch switch that judges each pitch as ball or strike and keeps the ball/strike count for the current batter. It feeds the same pulse interfaces the batting side feeds. Its walk pulse enters the base logic as a single, and its strikeout pulse enters the out-count logic alongside the batting out pulse. It sits on the divided game clock next to the batting blocks.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: divided game clock; all state on posedge
- `reset_n` in 1: asynchronous, active-low reset
- `pitch_sw_n` in 1: raw pitch switch, active-low; held = roulette spinning, release = pitch thrown
- `pa_end` in 1: one-cycle pulse; the plate appearance ended by the bat (any hit pulse or batting out pulse)
- `change_pulse` in 1: one-cycle pulse at the side change
- `walk_pulse` out 1: one-cycle pulse on the 4th ball; wired into hit1 of the base input
- `strikeout_pulse` out 1: one-cycle pulse on the 3rd strike; ORed into out-count input
- `ball_led` out 3: thermometer count of balls (001, 011, 111)
- `strike_led` out 2: thermometer count of strikes (01, 11)
- `pitch_led` out 8: one-hot roulette position

## Operation
- Input capture: `pitch_sw_n` goes through a 2-FF synchronizer; `pitch` = inverted synchronized level. No debounce, because `clk` is already divided.
- FSM states: IDLE, SPIN, JUDGE.
  - IDLE→SPIN on `pitch`=1. The roulette position `pos` (3 bits) resets to 0 on entry.
  - SPIN: `pos` increments by 1 per cycle, wrapping 7→0. SPIN→JUDGE when `pitch`=0; `pos` freezes.
  - JUDGE: one cycle, unconditionally →IDLE.
- Judgment of frozen `pos`:
  - 0–3 = strike; 4–7 = ball.
  - Foul handling of `pos`=3 is covered under Configuration.
- Count update, taking effect at the edge leaving JUDGE:
  - Ball with balls<3: balls+1.
  - Ball with balls=3: `walk_pulse`=1; balls and strikes clear to 0.
  - Strike with strikes<2: strikes+1.
  - Strike with strikes=2: `strikeout_pulse`=1; balls and strikes clear to 0.
- Count clear: `pa_end` or `change_pulse` clears balls and strikes to 0 at the next edge.
- Priority in the same cycle:
  - Clear beats JUDGE: the count clears and the JUDGE result is discarded (no pulse).
  - `walk_pulse` and `strikeout_pulse` are never high together.
- `change_pulse` also forces the FSM to IDLE. A pitch in SPIN is abandoned; the switch must be released and pressed again.
- `pitch_led`:
  - 8'h00 after reset.
  - During SPIN and JUDGE it shows 1<<`pos`.
  - In IDLE it holds the last judged position until the next SPIN entry, a clear, or reset (clear/reset → 8'h00).
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no pulse is emitted.

## Timing
- Reset values:
  - FSM=IDLE, `pos`=0, balls=0, strikes=0, synchronizer FFs=1 (switch released).
  - `walk_pulse`=0, `strikeout_pulse`=0, `ball_led`=3'b000, `strike_led`=2'b00, `pitch_led`=8'h00.
- Synchronizer latency: 2 cycles from a `pitch_sw_n` change to `pitch`.
- Edge sequence:
  - Edge k: SPIN→JUDGE.
  - Edge k+1: the count update and any pulse appear.
  - Edge k+2: the pulse drops.
- Pulses are registered outputs, exactly one cycle wide.
- LED outputs are registered and change on the same edge as the count.
- `pa_end`/`change_pulse` sampled at edge j: counts read 0 after edge j.
- Shortest pitch: `pitch` high for 1 cycle. SPIN lasts 1 cycle and `pos`=0 is judged as a strike.

## Configuration
- `PITCH_FOUL_EN` defined: `pos`=3 is a foul.
  - strikes<2 → strikes+1.
  - strikes=2 → no count change and no pulse.
  - `pitch_led` still shows position 3.
- `PITCH_FOUL_EN` undefined: `pos`=3 is an ordinary strike; strikes=2 → `strikeout_pulse`.

## Test plan
- Reset, then 4 pitches frozen at `pos`=5:
  - `ball_led` steps 001, 011, 111, then 000.
  - `walk_pulse` is high for exactly 1 cycle, 1 edge after the 4th JUDGE.
- 3 pitches frozen at `pos`=1: `strike_led` steps 01, 11, 00; `strikeout_pulse` is high 1 cycle; `walk_pulse` stays 0.
- Count at 2 strikes, pitch frozen at `pos`=3:
  - With `PITCH_FOUL_EN`: `strike_led` stays 11 and there is no pulse.
  - Without it: `strikeout_pulse` fires and the count goes to 0.
- Count at 3 balls/2 strikes, `pa_end` asserted in the JUDGE cycle of a `pos`=6 pitch: counts go to 0, no `walk_pulse`, `pitch_led`=8'h00.
- Hold the switch for 10 cycles (`pos` wraps to 1 and is frozen there), then assert `change_pulse` during a following SPIN:
  - The first pitch shows `pitch_led`=8'h02 and counts one strike.
  - `change_pulse` returns the FSM to IDLE, clears the counts, and emits no pulse.
- Drop `reset_n` while in SPIN with 2 balls: all outputs return to zero at once; after release, the first press restarts with `pos`=0.
